// File: rtl/conv_pkg.sv
// Types and default sizes shared by the weight FIFO, the weight loader and the conv controllers.
package conv_pkg;

  localparam int KERNAL_SIZE_DEF = 5;
  localparam int FIFO_SIZE_DEF   = KERNAL_SIZE_DEF * KERNAL_SIZE_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rd_valid_pipe.sv
// Single-bit delay line that follows each read strobe through the weight memory latency.
module rd_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] line_q, line_d;

  always_comb begin
    line_d    = line_q;
    line_d[0] = valid_i;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) line_q <= '0;
    else       line_q <= line_d;
  end

  assign valid_o = line_q[DEPTH-1];

endmodule

// File: rtl/weight_stream_loader.sv
// Reads one kernel from the weight memory and shifts it word by word into the weight FIFO.
// State table: IDLE | waiting for start; ISSUE | issuing reads; DRAIN | waiting for in-flight pushes; DONE | one-cycle done pulse.
module weight_stream_loader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNAL_SIZE = KERNAL_SIZE_DEF,
  parameter int FIFO_SIZE   = KERNAL_SIZE * KERNAL_SIZE,
  parameter int ADDR_WIDTH  = 10,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] kernel_base,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  fifo_enable,
  output logic [DATA_WIDTH-1:0] fifo_wr_data
);

  localparam int               CNT_W    = $clog2(FIFO_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FIFO_SIZE - 1);
  localparam logic [CNT_W-1:0] ALL_CNT  = CNT_W'(FIFO_SIZE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      push_cnt_q, push_cnt_d;
  logic                  fifo_en_q, fifo_en_d;
  logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic                  rd_fire;
  logic                  rd_tail;

  rd_valid_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rd_valid_pipe (
    .clk    (clk),
    .reset  (reset),
    .valid_i(rd_fire),
    .valid_o(rd_tail)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    push_cnt_d  = push_cnt_q;
    rd_fire     = 1'b0;
    fifo_en_d   = rd_tail;
    fifo_data_d = rd_tail ? mem_rd_data : fifo_data_q;

    // Pushes are counted when the read returns, so DRAIN exits right after the final word is captured.
    if (rd_tail) push_cnt_d = push_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ISSUE;
          base_d      = kernel_base;
          issue_cnt_d = '0;
          push_cnt_d  = '0;
        end
      end
      ISSUE: begin
        if (!hold) begin
          rd_fire     = 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (push_cnt_q == ALL_CNT) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      push_cnt_q  <= '0;
      fifo_en_q   <= 1'b0;
      fifo_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      push_cnt_q  <= push_cnt_d;
      fifo_en_q   <= fifo_en_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign mem_rd_en    = rd_fire;
  assign mem_addr     = base_q + ADDR_WIDTH'(issue_cnt_q);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign fifo_enable  = fifo_en_q;
  assign fifo_wr_data = fifo_data_q;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Bench for weight_stream_loader: four loaders with read latency 1..4 share stimulus, each with its own memory model.
module tb_weight_stream_loader;

  localparam int NI = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FS = 25;

  logic             clk = 1'b0;
  logic             reset;
  logic [NI-1:0]    start_v;
  logic [AW-1:0]    kernel_base;
  logic             hold;
  logic             busy   [NI];
  logic             done_o [NI];
  logic             rd_en  [NI];
  logic             fe     [NI];
  logic [AW-1:0]    addr   [NI];
  logic [DW-1:0]    wd     [NI];
  logic [DW-1:0]    rdata  [NI];

  int          cyc = 0;
  logic [31:0] salt = 32'd100;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return DW'(a) + salt;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DW-1:0] dp [g+1];
    always @(posedge clk) begin
      dp[0] <= rd_en[g] ? mem_val(addr[g]) : 32'hDEAD_BEEF;
      for (int i = 1; i < g + 1; i++) dp[i] <= dp[i-1];
    end
    assign rdata[g] = dp[g];

    weight_stream_loader #(
      .DATA_WIDTH (DW),
      .KERNAL_SIZE(5),
      .FIFO_SIZE  (FS),
      .ADDR_WIDTH (AW),
      .RD_LATENCY (g + 1)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start_v[g]),
      .kernel_base (kernel_base),
      .hold        (hold),
      .busy        (busy[g]),
      .done        (done_o[g]),
      .mem_rd_en   (rd_en[g]),
      .mem_addr    (addr[g]),
      .mem_rd_data (rdata[g]),
      .fifo_enable (fe[g]),
      .fifo_wr_data(wd[g])
    );
  end

  // Observed activity, sampled mid-cycle
  logic [DW-1:0] push_d [NI][$];
  int            push_c [NI][$];
  logic [AW-1:0] rd_a   [NI][$];
  int            rd_c   [NI][$];
  int            done_c [NI][$];
  logic          busy_first [NI];
  logic          busy_after [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (fe[i]) begin
        push_d[i].push_back(wd[i]);
        push_c[i].push_back(cyc);
      end
      if (rd_en[i]) begin
        rd_a[i].push_back(addr[i]);
        rd_c[i].push_back(cyc);
      end
      if (done_o[i]) done_c[i].push_back(cyc);
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < NI; i++) begin
      push_d[i].delete();
      push_c[i].delete();
      rd_a[i].delete();
      rd_c[i].delete();
      done_c[i].delete();
    end
  endtask

  // Reference schedule: reads in every non-held cycle from T+1; word k pushed L+1 cycles after its read.
  int            exp_rc [$];
  logic [AW-1:0] exp_ra [$];

  task automatic build_expected(input int t0, input logic [AW-1:0] base, input int hs, input int hl);
    int c;
    c = t0 + 1;
    exp_rc.delete();
    exp_ra.delete();
    while (exp_rc.size() < FS) begin
      if (!(hl > 0 && c >= t0 + hs && c < t0 + hs + hl)) begin
        exp_ra.push_back(base + AW'(exp_rc.size()));
        exp_rc.push_back(c);
      end
      c++;
    end
  endtask

  // Starts a load on every instance; hold covers cycles t0+hs .. t0+hs+hl-1.
  task automatic run_load(input logic [AW-1:0] base, input int hs, input int hl,
                          input bit pokes, output int t0);
    clear_mon();
    kernel_base = base;
    start_v     = '1;
    @(posedge clk); #1;
    t0          = cyc - 1;
    start_v     = '0;
    kernel_base = AW'($urandom);
    for (int i = 0; i < NI; i++) busy_first[i] = busy[i];
    for (int c = t0 + 2; c <= t0 + 46; c++) begin
      @(posedge clk); #1;
      hold = (hl > 0 && c >= t0 + hs && c < t0 + hs + hl);
      for (int i = 0; i < NI; i++)
        start_v[i] = pokes && ((c == t0 + 10) || (c == t0 + 28 + i));
      if (c == t0 + 20) kernel_base = AW'($urandom);
    end
    hold    = 1'b0;
    start_v = '0;
    for (int i = 0; i < NI; i++) busy_after[i] = busy[i];
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    start_v     = '0;
    hold        = 1'b0;
    kernel_base = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({busy[i], done_o[i], rd_en[i], fe[i]} !== 4'b0 || addr[i] !== '0 || wd[i] !== '0) begin
        failures++;
        $display("FAIL reset_state L=%0d got busy=%b done=%b rd=%b fe=%b addr=%0d data=%0h, expected all zero",
                 i + 1, busy[i], done_o[i], rd_en[i], fe[i], addr[i], wd[i]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int t0, errs;
    salt = 32'd100;
    run_load(AW'(40), 0, 0, 1'b0, t0);
    checks++;
    if (push_d[0].size() != FS) begin
      failures++;
      $display("FAIL basic_count got=%0d expected=%0d", push_d[0].size(), FS);
    end
    errs = 0;
    for (int k = 0; k < FS; k++) begin
      if (push_d[0][k] !== DW'(140 + k) || push_c[0][k] != t0 + 3 + k) errs++;
      if (rd_a[0][k] !== AW'(40 + k) || rd_c[0][k] != t0 + 1 + k) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL basic_sequence got %0d wrong reads/pushes, expected 0", errs);
    end
    checks++;
    if (done_c[0].size() != 1 || done_c[0][0] != t0 + 28) begin
      failures++;
      $display("FAIL basic_done got %0d pulses first at offset %0d, expected 1 at offset 28",
               done_c[0].size(), (done_c[0].size() > 0) ? done_c[0][0] - t0 : -1);
    end
    checks++;
    if (push_d[0].size() != FS || push_d[0][0] !== 32'd140 || push_d[0][FS-1] !== 32'd164) begin
      failures++;
      $display("FAIL basic_taps got tap1/tap25 not 140/164 (pushes=%0d)", push_d[0].size());
    end
    checks++;
    if (busy_first[0] !== 1'b1 || busy_after[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy got first=%b after=%b, expected 1 and 0", busy_first[0], busy_after[0]);
    end
  endtask

  task automatic test_hold();
    int t0, errs, lat;
    logic [AW-1:0] base;
    salt = $urandom;
    base = AW'($urandom_range(0, 900));
    run_load(base, 11, 3, 1'b0, t0);
    build_expected(t0, base, 11, 3);
    checks++;
    if (rd_c[0].size() != FS || rd_c[0][10] - rd_c[0][9] != 4) begin
      failures++;
      $display("FAIL hold_gap got reads=%0d, expected %0d reads with a 3-cycle gap after the 10th", rd_c[0].size(), FS);
    end
    for (int i = 0; i < NI; i++) begin
      lat  = i + 1;
      errs = 0;
      for (int k = 0; k < FS; k++) begin
        if (push_d[i][k] !== mem_val(exp_ra[k]) || push_c[i][k] != exp_rc[k] + 1 + lat) errs++;
        if (rd_a[i][k] !== exp_ra[k] || rd_c[i][k] != exp_rc[k]) errs++;
      end
      checks++;
      if (errs != 0 || push_d[i].size() != FS) begin
        failures++;
        $display("FAIL hold_data L=%0d got %0d errors and %0d pushes, expected 0 and %0d", lat, errs, push_d[i].size(), FS);
      end
      checks++;
      if (done_c[i].size() != 1 || done_c[i][0] != t0 + 30 + lat) begin
        failures++;
        $display("FAIL hold_done L=%0d got %0d pulses, expected 1 at offset %0d", lat, done_c[i].size(), 30 + lat);
      end
    end
  endtask

  task automatic test_wrap();
    int t0, errs, lat;
    salt = $urandom;
    run_load(AW'(1020), 0, 0, 1'b0, t0);
    build_expected(t0, AW'(1020), 0, 0);
    checks++;
    if (rd_a[0].size() != FS || rd_a[0][3] !== AW'(1023) || rd_a[0][4] !== AW'(0) || rd_a[0][24] !== AW'(20)) begin
      failures++;
      $display("FAIL wrap_addr got reads=%0d, expected 1020..1023 then 0..20", rd_a[0].size());
    end
    for (int i = 0; i < NI; i++) begin
      lat  = i + 1;
      errs = 0;
      for (int k = 0; k < FS; k++)
        if (push_d[i][k] !== mem_val(exp_ra[k]) || push_c[i][k] != exp_rc[k] + 1 + lat) errs++;
      checks++;
      if (errs != 0 || push_d[i].size() != FS) begin
        failures++;
        $display("FAIL wrap_data L=%0d got %0d errors and %0d pushes, expected 0 and %0d", lat, errs, push_d[i].size(), FS);
      end
    end
  endtask

  task automatic test_busy_start();
    int t0, errs, lat;
    logic [AW-1:0] base;
    salt = $urandom;
    base = AW'($urandom);
    run_load(base, 0, 0, 1'b1, t0);
    build_expected(t0, base, 0, 0);
    for (int i = 0; i < NI; i++) begin
      lat  = i + 1;
      errs = 0;
      for (int k = 0; k < FS; k++)
        if (push_d[i][k] !== mem_val(exp_ra[k]) || push_c[i][k] != exp_rc[k] + 1 + lat) errs++;
      checks++;
      if (errs != 0 || push_d[i].size() != FS || rd_c[i].size() != FS) begin
        failures++;
        $display("FAIL busy_start L=%0d got %0d errors, %0d pushes, %0d reads, expected 0, %0d, %0d",
                 lat, errs, push_d[i].size(), rd_c[i].size(), FS, FS);
      end
      checks++;
      if (done_c[i].size() != 1 || busy_after[i] !== 1'b0) begin
        failures++;
        $display("FAIL busy_start_done L=%0d got %0d pulses busy_after=%b, expected 1 pulse and idle", lat, done_c[i].size(), busy_after[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0, n, errs, lat;
    int np [NI];
    logic [AW-1:0] base;
    salt = $urandom;
    base = AW'($urandom);
    clear_mon();
    kernel_base = base;
    start_v     = '1;
    @(posedge clk); #1;
    start_v = '0;
    n = 0;
    while (push_d[0].size() < 12 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL reset_mid_timeout got %0d pushes, expected 12 within 60 cycles", push_d[0].size());
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({busy[i], fe[i], rd_en[i]} !== 3'b000) begin
        failures++;
        $display("FAIL reset_mid_outputs L=%0d got busy=%b fe=%b rd=%b, expected 0 0 0", i + 1, busy[i], fe[i], rd_en[i]);
      end
      np[i] = push_d[i].size();
    end
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      errs = 0;
      for (int k = 0; k < np[i]; k++)
        if (push_d[i][k] !== mem_val(base + AW'(k))) errs++;
      checks++;
      if (push_d[i].size() != np[i] || errs != 0 || done_c[i].size() != 0) begin
        failures++;
        $display("FAIL reset_mid_abort L=%0d got %0d pushes (had %0d), %0d bad, %0d done, expected no change and no done",
                 i + 1, push_d[i].size(), np[i], errs, done_c[i].size());
      end
    end
    salt = $urandom;
    base = AW'($urandom);
    run_load(base, 0, 0, 1'b0, t0);
    build_expected(t0, base, 0, 0);
    for (int i = 0; i < NI; i++) begin
      lat  = i + 1;
      errs = 0;
      for (int k = 0; k < FS; k++)
        if (push_d[i][k] !== mem_val(exp_ra[k]) || push_c[i][k] != exp_rc[k] + 1 + lat) errs++;
      checks++;
      if (errs != 0 || push_d[i].size() != FS || done_c[i].size() != 1) begin
        failures++;
        $display("FAIL reset_mid_reload L=%0d got %0d errors, %0d pushes, %0d done, expected 0, %0d, 1",
                 lat, errs, push_d[i].size(), done_c[i].size(), FS);
      end
    end
  endtask

  task automatic test_latency_sweep();
    int t0, errs, lat;
    logic [AW-1:0] base;
    for (int it = 0; it < 3; it++) begin
      salt = $urandom;
      base = AW'($urandom);
      run_load(base, 0, 0, 1'b0, t0);
      build_expected(t0, base, 0, 0);
      for (int i = 0; i < NI; i++) begin
        lat = i + 1;
        checks++;
        if (push_c[i].size() == 0 || push_c[i][0] != t0 + 2 + lat) begin
          failures++;
          $display("FAIL sweep_first_push L=%0d got offset %0d, expected %0d",
                   lat, (push_c[i].size() > 0) ? push_c[i][0] - t0 : -1, 2 + lat);
        end
        checks++;
        if (done_c[i].size() != 1 || done_c[i][0] != t0 + 27 + lat) begin
          failures++;
          $display("FAIL sweep_done L=%0d got %0d pulses first at offset %0d, expected 1 at %0d",
                   lat, done_c[i].size(), (done_c[i].size() > 0) ? done_c[i][0] - t0 : -1, 27 + lat);
        end
        errs = 0;
        for (int k = 0; k < FS; k++)
          if (push_d[i][k] !== mem_val(exp_ra[k])) errs++;
        checks++;
        if (errs != 0 || push_d[i].size() != FS) begin
          failures++;
          $display("FAIL sweep_data L=%0d got %0d errors and %0d pushes, expected 0 and %0d", lat, errs, push_d[i].size(), FS);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    test_latency_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_stream_loader.md
Name: weight_stream_loader

Overview:
- Producer end of the serial weight-load interface of the convolution layers.
- On a start request, reads one KERNAL_SIZE x KERNAL_SIZE kernel from a synchronous weight memory and pushes it word by word into the 25-entry shift-in weight FIFO, using fifo_enable as a write strobe.
- Ordering is arranged so that once loading completes, FIFO tap k holds the weight at kernel_base+k-1.
- Sits between the weight ROM/BRAM and the FIFO feeding the 25 MAC lanes.

Parameters:
- DATA_WIDTH, 32, weight word width.
- KERNAL_SIZE, 5, kernel edge length.
- FIFO_SIZE, KERNAL_SIZE*KERNAL_SIZE, words per kernel load (25).
- ADDR_WIDTH, 10, weight memory address width.
- RD_LATENCY, 1, weight memory read latency in cycles; legal range 1..4.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  load request; sampled only in IDLE.
- kernel_base  input  ADDR_WIDTH  first weight address; captured when start is accepted.
- hold  input  1  downstream stall; suppresses new memory reads only.
- busy  output  1  high from the cycle after start is accepted through the done cycle.
- done  output  1  one-cycle pulse after the final push.
- mem_rd_en  output  1  weight memory read strobe.
- mem_addr  output  ADDR_WIDTH  weight memory read address.
- mem_rd_data  input  DATA_WIDTH  read data, valid RD_LATENCY cycles after mem_rd_en.
- fifo_enable  output  1  shift strobe to the weight FIFO.
- fifo_wr_data  output  DATA_WIDTH  word to shift in; valid while fifo_enable is high.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, done, mem_rd_en, fifo_enable all 0; mem_addr, fifo_wr_data, counters and valid pipe all 0.
- Reset mid-load aborts. In-flight reads are discarded, and no fifo_enable is asserted in any cycle after the reset edge.
- States:
  - IDLE: start=1 → ISSUE. kernel_base is captured, issue count and push count are cleared.
  - ISSUE: each cycle with hold=0, drive mem_rd_en=1, mem_addr=base+issue_cnt, then increment issue_cnt. With hold=1, mem_rd_en=0 and the address is held. After read number FIFO_SIZE has issued → DRAIN.
  - DRAIN: wait until push_cnt reaches FIFO_SIZE → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; base+24 may wrap past the top of memory.
- Read pipeline:
  - Each mem_rd_en enters a RD_LATENCY-deep valid delay line.
  - When the tail of the delay line is high, mem_rd_data is registered into fifo_wr_data, and fifo_enable=1 in the following cycle.
  - Push-to-read latency is therefore RD_LATENCY+1 cycles.
- hold does not stop pushes for reads already in flight.
- Exactly FIFO_SIZE fifo_enable pulses occur per load, in address order. The first word pushed ends up at the deepest FIFO tap (tap 1).
- Timing with no hold (start accepted at edge T):
  - mem_rd_en high in cycles T+1..T+25.
  - fifo_enable high in cycles T+2+RD_LATENCY..T+26+RD_LATENCY.
  - done in cycle T+27+RD_LATENCY.
  - busy falls together with done.
- Each cycle of hold during ISSUE delays the tail of the schedule by one cycle.
- start while busy (including the DONE cycle) is ignored; no queueing.
- kernel_base changes after acceptance have no effect on the current load.
- fifo_enable is never high outside a load. fifo_wr_data keeps its last value when fifo_enable=0.

Decomposition:
- Shared package (conv_pkg):
  - State encoding localparams: IDLE, ISSUE, DRAIN, DONE.
  - Default FIFO_SIZE/KERNAL_SIZE constants shared with the weight FIFO and the conv controllers.
- One sub-module: rd_valid_pipe, a RD_LATENCY-deep single-bit shift line with synchronous reset, used for read-valid tracking.
- issue_cnt and push_cnt are 5-bit counters, sized as $clog2(FIFO_SIZE+1), kept in the top level.

Test Plan:
- Basic load: RD_LATENCY=1, memory model mem[a]=a+100, start with kernel_base=40, no hold → 25 fifo_enable pulses in cycles T+3..T+27 carrying 140..164; done in T+28. Feeding the real weight FIFO gives fifo_data_out_1=140 and fifo_data_out_25=164.
- Hold mid-issue: hold=1 for 3 cycles after the 10th read → mem_rd_en gap of exactly 3 cycles; pushes still 140..164 in order; done 3 cycles later than the basic case; total pulses = 25.
- Address wrap: ADDR_WIDTH=10, kernel_base=1020 → addresses 1020..1023 then 0..20; data order matches.
- Busy start: pulse start at load cycle 10 and again in the done cycle → ignored; exactly one load of 25 pushes, one done pulse.
- Reset mid-load: assert reset after the 12th push → next cycle busy=0, fifo_enable=0, mem_rd_en=0; no further pushes. A fresh start then yields a full 25-word load.
- Latency sweep: RD_LATENCY=1..4 → first fifo_enable at T+2+RD_LATENCY; done at T+27+RD_LATENCY; data correct for each setting.
